// File: rtl/io881_mem_pkg.sv
// ============================================================================
//  Module   : io881_mem_pkg
//  Purpose  : Shared sizes, port ids and controller state encoding for the
//             fetcher / execution-unit memory interface.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package io881_mem_pkg;

    localparam int SRAM_ADDR_SIZE = 15;
    localparam int DATA_SIZE      = 8;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DP = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } mem_state_e;

    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_DP) ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_rr_arbiter.sv
// ============================================================================
//  Module   : mem_rr_arbiter
//  Purpose  : Two-way round-robin grant with per-port masking.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_rr_arbiter
    import io881_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       ptr,
    output logic       grant_valid,
    output logic       grant_port,
    output logic       ptr_next
);

    logic [1:0] eligible;

    // The pointer only moves when both ports compete.
    always_comb begin
        eligible    = req & ~mask;
        grant_valid = |eligible;
        grant_port  = ptr;
        ptr_next    = ptr;
        case (eligible)
            2'b01:   grant_port = PORT_IF;
            2'b10:   grant_port = PORT_DP;
            2'b11: begin
                grant_port = ptr;
                ptr_next   = ~ptr;
            end
            default: grant_port = ptr;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sram_controller.sv
// ============================================================================
//  Module   : sram_controller
//  Purpose  : Async SRAM responder for fetch reads and data-port read/write,
//             with round-robin arbitration and programmable wait states.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sram_controller
    import io881_mem_pkg::*;
#(
    parameter int SRAM_ADDR_SIZE = io881_mem_pkg::SRAM_ADDR_SIZE,
    parameter int DATA_SIZE      = io881_mem_pkg::DATA_SIZE,
    parameter int WAIT_STATES    = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [SRAM_ADDR_SIZE-1:0] if_addr,
    input  logic                      if_rd_en,
    output logic [DATA_SIZE-1:0]      if_d_out,
    output logic                      if_ack,
    input  logic [SRAM_ADDR_SIZE-1:0] dp_addr,
    input  logic                      dp_rd_en,
    input  logic                      dp_wr_en,
    input  logic [DATA_SIZE-1:0]      dp_d_in,
    output logic [DATA_SIZE-1:0]      dp_d_out,
    output logic                      dp_ack,
    output logic [SRAM_ADDR_SIZE-1:0] sram_addr,
    output logic [DATA_SIZE-1:0]      sram_d_out,
    output logic                      sram_d_oe,
    input  logic [DATA_SIZE-1:0]      sram_d_in,
    output logic                      sram_ce_n,
    output logic                      sram_oe_n,
    output logic                      sram_we_n
);

    localparam int                CNT_W    = $clog2(WAIT_STATES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_STATES - 1);

    mem_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      port_q, port_d;
    logic                      write_q, write_d;
    logic                      ptr_q, ptr_d;
    logic [1:0]                mask_q, mask_d;
    logic [SRAM_ADDR_SIZE-1:0] addr_q, addr_d;
    logic [DATA_SIZE-1:0]      wdata_q, wdata_d;
    logic                      d_oe_q, d_oe_d;
    logic                      ce_n_q, ce_n_d;
    logic                      oe_n_q, oe_n_d;
    logic                      we_n_q, we_n_d;
    logic                      if_ack_q, if_ack_d;
    logic                      dp_ack_q, dp_ack_d;
    logic [DATA_SIZE-1:0]      if_rdata_q, if_rdata_d;
    logic [DATA_SIZE-1:0]      dp_rdata_q, dp_rdata_d;

    logic                      grant_valid;
    logic                      grant_port;
    logic                      arb_ptr_next;
    logic                      grant_write;

    mem_rr_arbiter u_arbiter (
        .req         ({dp_rd_en | dp_wr_en, if_rd_en}),
        .mask        (mask_q),
        .ptr         (ptr_q),
        .grant_valid (grant_valid),
        .grant_port  (grant_port),
        .ptr_next    (arb_ptr_next)
    );

    // A data-port request with both enables set is treated as a write.
    assign grant_write = (grant_port == PORT_DP) && dp_wr_en;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        port_d     = port_q;
        write_d    = write_q;
        ptr_d      = ptr_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        d_oe_d     = d_oe_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        if_ack_d   = 1'b0;
        dp_ack_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        dp_rdata_d = dp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                mask_d = 2'b00;
                if (grant_valid) begin
                    port_d  = grant_port;
                    write_d = grant_write;
                    ptr_d   = arb_ptr_next;
                    addr_d  = (grant_port == PORT_DP) ? dp_addr : if_addr;
                    ce_n_d  = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_ACCESS;
                    if (grant_write) begin
                        wdata_d = dp_d_in;
                        we_n_d  = 1'b0;
                        d_oe_d  = 1'b1;
                    end else begin
                        oe_n_d  = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    state_d = ST_ACK;
                    if (!write_q) begin
                        if (port_q == PORT_IF) if_rdata_d = sram_d_in;
                        else                   dp_rdata_d = sram_d_in;
                    end
                    if_ack_d = (port_q == PORT_IF);
                    dp_ack_d = (port_q == PORT_DP);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK: begin
                // Address and write data stay driven here for hold time.
                ce_n_d  = 1'b1;
                d_oe_d  = 1'b0;
                mask_d  = port_onehot(port_q);
                state_d = ST_IDLE;
            end
            default: begin
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                d_oe_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            port_q     <= PORT_IF;
            write_q    <= 1'b0;
            ptr_q      <= PORT_IF;
            mask_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            d_oe_q     <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            if_ack_q   <= 1'b0;
            dp_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dp_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            port_q     <= port_d;
            write_q    <= write_d;
            ptr_q      <= ptr_d;
            mask_q     <= mask_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            d_oe_q     <= d_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            if_ack_q   <= if_ack_d;
            dp_ack_q   <= dp_ack_d;
            if_rdata_q <= if_rdata_d;
            dp_rdata_q <= dp_rdata_d;
        end
    end

    assign sram_addr  = addr_q;
    assign sram_d_out = wdata_q;
    assign sram_d_oe  = d_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign if_ack     = if_ack_q;
    assign dp_ack     = dp_ack_q;
    assign if_d_out   = if_rdata_q;
    assign dp_d_out   = dp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
// ============================================================================
//  Module   : tb_sram_controller
//  Purpose  : Directed self-checking bench for sram_controller (WS=2 and WS=1).
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sram_controller;

    logic        clk;
    logic        reset_n;

    logic [14:0] if_addr, dp_addr, sram_addr;
    logic        if_rd_en, dp_rd_en, dp_wr_en;
    logic [7:0]  dp_d_in, if_d_out, dp_d_out, sram_d_out, sram_d_in;
    logic        if_ack, dp_ack, sram_d_oe, sram_ce_n, sram_oe_n, sram_we_n;

    logic [14:0] f_if_addr, f_dp_addr, f_sram_addr;
    logic        f_if_rd_en, f_dp_rd_en, f_dp_wr_en;
    logic [7:0]  f_dp_d_in, f_if_d_out, f_dp_d_out, f_sram_d_out, f_sram_d_in;
    logic        f_if_ack, f_dp_ack, f_sram_d_oe, f_sram_ce_n, f_sram_oe_n, f_sram_we_n;

    logic [7:0]  mem [0:32767];
    logic        bw_en;
    logic [14:0] bw_addr;
    logic [7:0]  bw_data;

    int n_cmp = 0;
    int n_err = 0;
    int viol  = 0;

    sram_controller #(.WAIT_STATES(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_addr(if_addr), .if_rd_en(if_rd_en), .if_d_out(if_d_out), .if_ack(if_ack),
        .dp_addr(dp_addr), .dp_rd_en(dp_rd_en), .dp_wr_en(dp_wr_en), .dp_d_in(dp_d_in),
        .dp_d_out(dp_d_out), .dp_ack(dp_ack),
        .sram_addr(sram_addr), .sram_d_out(sram_d_out), .sram_d_oe(sram_d_oe),
        .sram_d_in(sram_d_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    sram_controller #(.WAIT_STATES(1)) dut_ws1 (
        .clk(clk), .reset_n(reset_n),
        .if_addr(f_if_addr), .if_rd_en(f_if_rd_en), .if_d_out(f_if_d_out), .if_ack(f_if_ack),
        .dp_addr(f_dp_addr), .dp_rd_en(f_dp_rd_en), .dp_wr_en(f_dp_wr_en), .dp_d_in(f_dp_d_in),
        .dp_d_out(f_dp_d_out), .dp_ack(f_dp_ack),
        .sram_addr(f_sram_addr), .sram_d_out(f_sram_d_out), .sram_d_oe(f_sram_d_oe),
        .sram_d_in(f_sram_d_in), .sram_ce_n(f_sram_ce_n), .sram_oe_n(f_sram_oe_n),
        .sram_we_n(f_sram_we_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: combinational read while selected, write on clock while strobed.
    assign sram_d_in   = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'hEE;
    assign f_sram_d_in = (!f_sram_ce_n && !f_sram_oe_n) ? mem[f_sram_addr] : 8'hEE;

    always @(posedge clk) begin
        if (bw_en) mem[bw_addr] <= bw_data;
        else if (!sram_ce_n && !sram_we_n && sram_d_oe) mem[sram_addr] <= sram_d_out;
    end

    always @(negedge clk) begin
        if ((!sram_oe_n && !sram_we_n) || (if_ack && dp_ack)) viol <= viol + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [14:0] a, input logic [7:0] d);
        bw_addr = a;
        bw_data = d;
        bw_en   = 1'b1;
        tick();
        bw_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        if_addr = '0; if_rd_en = 0; dp_addr = '0; dp_rd_en = 0; dp_wr_en = 0; dp_d_in = '0;
        f_if_addr = '0; f_if_rd_en = 0; f_dp_addr = '0; f_dp_rd_en = 0; f_dp_wr_en = 0;
        f_dp_d_in = '0;
        bw_en = 0; bw_addr = '0; bw_data = '0;
        preload(15'h1ABC, 8'h5A);
        preload(15'h0100, 8'h11);
        preload(15'h0200, 8'h22);
        preload(15'h0300, 8'h33);
        preload(15'h0400, 8'h44);
        preload(15'h0010, 8'h00);
        preload(15'h0020, 8'h00);
        n_cmp++;
        if ({if_ack, dp_ack, sram_ce_n, sram_oe_n, sram_we_n, sram_d_oe} !== 6'b001110) begin
            n_err++;
            $display("FAIL reset_strobes: got %b want 001110",
                     {if_ack, dp_ack, sram_ce_n, sram_oe_n, sram_we_n, sram_d_oe});
        end
        n_cmp++;
        if ({sram_addr, sram_d_out, if_d_out, dp_d_out} !== 39'd0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", {sram_addr, sram_d_out, if_d_out, dp_d_out});
        end
        n_cmp++;
        if ({f_if_ack, f_sram_ce_n, f_sram_oe_n} !== 3'b011) begin
            n_err++;
            $display("FAIL reset_ws1: got %b want 011", {f_if_ack, f_sram_ce_n, f_sram_oe_n});
        end
        reset_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({sram_ce_n, if_ack, dp_ack} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_idle: got %b want 100", {sram_ce_n, if_ack, dp_ack});
        end
    endtask

    task automatic test_fetch_read();
        int lows;
        if_addr  = 15'h1ABC;
        if_rd_en = 1'b1;
        tick();
        n_cmp++;
        if ({sram_oe_n, sram_ce_n, sram_we_n, if_ack, sram_addr} !== {4'b0010, 15'h1ABC}) begin
            n_err++;
            $display("FAIL fetch_c2: got %b_%h want 0010_1abc",
                     {sram_oe_n, sram_ce_n, sram_we_n, if_ack}, sram_addr);
        end
        tick();
        n_cmp++;
        if ({sram_oe_n, if_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL fetch_c3: got %b want 00", {sram_oe_n, if_ack});
        end
        tick();
        n_cmp++;
        if ({if_ack, dp_ack, sram_oe_n, sram_ce_n, if_d_out} !== {4'b1010, 8'h5A}) begin
            n_err++;
            $display("FAIL fetch_ack: got %b_%h want 1010_5a",
                     {if_ack, dp_ack, sram_oe_n, sram_ce_n}, if_d_out);
        end
        tick();
        tick();
        n_cmp++;
        if ({if_ack, sram_ce_n} !== 2'b01) begin
            n_err++;
            $display("FAIL fetch_no_reissue: got %b want 01", {if_ack, sram_ce_n});
        end
        if_rd_en = 1'b0;
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!sram_ce_n || if_ack) lows++;
        end
        n_cmp++;
        if (lows != 0 || if_d_out !== 8'h5A) begin
            n_err++;
            $display("FAIL fetch_quiet: got activity %0d data %h want 0 5a", lows, if_d_out);
        end
    endtask

    task automatic test_write_read();
        int  lat;
        bit  seen;
        dp_addr  = 15'h0010;
        dp_d_in  = 8'hC3;
        dp_wr_en = 1'b1;
        tick();
        n_cmp++;
        if ({sram_we_n, sram_oe_n, sram_ce_n, sram_d_oe, sram_addr, sram_d_out}
                !== {4'b0101, 15'h0010, 8'hC3}) begin
            n_err++;
            $display("FAIL write_c2: got %b_%h_%h want 0101_0010_c3",
                     {sram_we_n, sram_oe_n, sram_ce_n, sram_d_oe}, sram_addr, sram_d_out);
        end
        tick();
        n_cmp++;
        if ({sram_we_n, dp_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL write_c3: got %b want 00", {sram_we_n, dp_ack});
        end
        tick();
        n_cmp++;
        if ({dp_ack, if_ack, sram_we_n, sram_ce_n, sram_d_oe, sram_addr, sram_d_out}
                !== {5'b10101, 15'h0010, 8'hC3}) begin
            n_err++;
            $display("FAIL write_ack: got %b_%h_%h want 10101_0010_c3",
                     {dp_ack, if_ack, sram_we_n, sram_ce_n, sram_d_oe}, sram_addr, sram_d_out);
        end
        dp_wr_en = 1'b0;
        tick();
        n_cmp++;
        if ({dp_ack, sram_ce_n, sram_d_oe} !== 3'b010 || mem[15'h0010] !== 8'hC3) begin
            n_err++;
            $display("FAIL write_done: got %b mem %h want 010 c3",
                     {dp_ack, sram_ce_n, sram_d_oe}, mem[15'h0010]);
        end
        dp_rd_en = 1'b1;
        seen = 0;
        lat  = 0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            tick();
            if (dp_ack) begin
                seen = 1;
                lat  = i;
            end
        end
        dp_rd_en = 1'b0;
        n_cmp++;
        if (!seen || lat != 4) begin
            n_err++;
            $display("FAIL readback_latency: got seen=%0d ticks=%0d want 1 4", seen, lat);
        end
        n_cmp++;
        if ({dp_d_out, if_d_out} !== {8'hC3, 8'h5A}) begin
            n_err++;
            $display("FAIL readback_data: got %h want c35a", {dp_d_out, if_d_out});
        end
        tick();
        n_cmp++;
        if (dp_ack !== 1'b0) begin
            n_err++;
            $display("FAIL readback_one_shot: got %b want 0", dp_ack);
        end
        tick();
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] ports [4];
        int         ticks [4];
        logic [7:0] data  [4];
        int         n_ack;
        logic [1:0] want_port;
        logic [7:0] want_data;
        n_ack    = 0;
        if_addr  = 15'h0100;
        dp_addr  = 15'h0200;
        if_rd_en = 1'b1;
        dp_rd_en = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if ((if_ack || dp_ack) && n_ack < 4) begin
                ports[n_ack] = {dp_ack, if_ack};
                ticks[n_ack] = i;
                data[n_ack]  = if_ack ? if_d_out : dp_d_out;
                n_ack++;
            end
        end
        if_rd_en = 1'b0;
        dp_rd_en = 1'b0;
        n_cmp++;
        if (n_ack != 4) begin
            n_err++;
            $display("FAIL contend_count: got %0d want 4", n_ack);
        end
        for (int k = 0; k < n_ack; k++) begin
            want_port = (k % 2 == 0) ? 2'b01 : 2'b10;
            want_data = (k % 2 == 0) ? 8'h11 : 8'h22;
            n_cmp++;
            if (ports[k] !== want_port || ticks[k] != 3 + 4 * k || data[k] !== want_data) begin
                n_err++;
                $display("FAIL contend_ack%0d: got port %b tick %0d data %h want %b %0d %h",
                         k, ports[k], ticks[k], data[k], want_port, 3 + 4 * k, want_data);
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid_write();
        int lat;
        bit seen;
        dp_addr  = 15'h0020;
        dp_d_in  = 8'h77;
        dp_wr_en = 1'b1;
        tick();
        n_cmp++;
        if (sram_we_n !== 1'b0) begin
            n_err++;
            $display("FAIL rstw_access: got we_n %b want 0", sram_we_n);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({sram_we_n, sram_ce_n, sram_d_oe, dp_ack, if_ack} !== 5'b11000
                || mem[15'h0020] !== 8'h00) begin
            n_err++;
            $display("FAIL rstw_async: got %b mem %h want 11000 00",
                     {sram_we_n, sram_ce_n, sram_d_oe, dp_ack, if_ack}, mem[15'h0020]);
        end
        #2;
        reset_n = 1'b1;
        seen = 0;
        lat  = 0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            tick();
            if (dp_ack) begin
                seen = 1;
                lat  = i;
            end
        end
        dp_wr_en = 1'b0;
        n_cmp++;
        if (!seen || lat != 3) begin
            n_err++;
            $display("FAIL rstw_reserve: got seen=%0d ticks=%0d want 1 3", seen, lat);
        end
        tick();
        n_cmp++;
        if (mem[15'h0020] !== 8'h77) begin
            n_err++;
            $display("FAIL rstw_mem: got %h want 77", mem[15'h0020]);
        end
        repeat (2) tick();
    endtask

    task automatic test_withdrawn();
        int acts;
        if_addr  = 15'h0300;
        if_rd_en = 1'b1;
        tick();
        if_rd_en = 1'b0;
        if_addr  = 15'h0400;
        tick();
        n_cmp++;
        if (sram_addr !== 15'h0300) begin
            n_err++;
            $display("FAIL wd_addr_hold: got %h want 0300", sram_addr);
        end
        tick();
        n_cmp++;
        if ({if_ack, if_d_out} !== {1'b1, 8'h33}) begin
            n_err++;
            $display("FAIL wd_ack: got %b_%h want 1_33", if_ack, if_d_out);
        end
        acts = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (if_ack || !sram_ce_n) acts++;
        end
        n_cmp++;
        if (acts != 0) begin
            n_err++;
            $display("FAIL wd_quiet: got %0d active cycles want 0", acts);
        end

        f_if_addr  = 15'h1ABC;
        f_if_rd_en = 1'b1;
        tick();
        n_cmp++;
        if ({f_sram_oe_n, f_sram_ce_n, f_if_ack} !== 3'b000) begin
            n_err++;
            $display("FAIL ws1_access: got %b want 000", {f_sram_oe_n, f_sram_ce_n, f_if_ack});
        end
        tick();
        f_if_rd_en = 1'b0;
        n_cmp++;
        if ({f_if_ack, f_sram_oe_n, f_if_d_out} !== {2'b11, 8'h5A}) begin
            n_err++;
            $display("FAIL ws1_ack: got %b_%h want 11_5a", {f_if_ack, f_sram_oe_n}, f_if_d_out);
        end
        tick();
        n_cmp++;
        if ({f_if_ack, f_sram_ce_n} !== 2'b01) begin
            n_err++;
            $display("FAIL ws1_release: got %b want 01", {f_if_ack, f_sram_ce_n});
        end
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_write_read();
        test_contention();
        test_reset_mid_write();
        test_withdrawn();
        n_cmp++;
        if (viol != 0) begin
            n_err++;
            $display("FAIL exclusivity: got %0d overlap cycles want 0", viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
